div_sequencer: RTL
==================

# div_sequencer

Multi-cycle RISC-V M-extension divide/remainder unit for the multicycle processor. It replaces single-cycle combinational division with a 32-step shift-subtract iteration under a small state machine. The controller issues an operation with a start/busy/done handshake and stalls its FSM until done. All RISC-V corner cases are resolved without iterating.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported; the iteration count equals XLEN.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a new operation. Sampled only in IDLE or DONE.
- `op`, input, 2: operation select. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `SrcA`, input, 32: dividend, captured on start acceptance.
- `SrcB`, input, 32: divisor, captured on start acceptance.
- `kill`, input, 1: synchronous abort of any in-flight operation.
- `busy`, output, 1: operation in progress (PREP, ITER, FIX).
- `done`, output, 1: one-cycle pulse; `result` is valid in this cycle.
- `result`, output, 32: quotient or remainder. Held until the next `done`.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- **IDLE / DONE**
  - `start=1` and `kill=0`: capture `op`, `SrcA`, `SrcB`, then go to PREP.
  - Otherwise go to (or stay in) IDLE.
- **PREP**
  - Signed ops (DIV, REM): record sign(SrcA) and sign(SrcA)^sign(SrcB). Replace each operand with its absolute value.
  - Clear the 33-bit partial remainder. Load the quotient register with |dividend|. Clear the 5-bit step counter.
  - Divisor == 0: result = 0xFFFFFFFF for DIV/DIVU, or the original SrcA for REM/REMU. Go to DONE.
  - DIV/REM with SrcA=0x80000000 and SrcB=0xFFFFFFFF: result = 0x80000000 for DIV, 0 for REM. Go to DONE.
  - All other cases: go to ITER.
- **ITER** (one step per cycle)
  - {rem, quo} shifts left by 1.
  - Trial = rem − divisor, computed at 33-bit width.
  - Trial non-negative: rem = trial and quo[0] = 1. Otherwise rem is unchanged and quo[0] = 0.
  - Counter increments. Leave ITER after step 32 (counter wraps 31→0).
- **FIX**
  - DIV: result = quotient, negated if the sign-XOR was recorded.
  - REM: result = remainder, negated if the dividend was negative. The remainder sign follows the dividend.
  - DIVU/REMU: result is the raw quotient or remainder.
  - Go to DONE.
- **DONE**: `done=1` for exactly one cycle. A new start may be accepted in this same cycle (back-to-back operation).
- **kill**: any state goes to IDLE on the next edge. No `done` is produced; `result` is unchanged. If `kill` and `start` are both high, `kill` wins and `start` is dropped.
- `start` in PREP, ITER or FIX is ignored; there is no queuing.
- `op`, `SrcA` and `SrcB` changing after acceptance have no effect.

## Timing
- Reset (asynchronous, `rst_n=0`): state IDLE, `busy=0`, `done=0`, `result=0`, all internal registers 0. Reset asserted mid-operation abandons it immediately.
- Cycle 0 is the cycle in which `start` is sampled high.
  - Normal path: PREP in cycle 1, ITER in cycles 2–33, FIX in cycle 34. `done` is high in cycle 35 (35-cycle latency).
  - Special case (zero divisor or signed overflow): `done` is high in cycle 2.
- `busy` is high from cycle 1 through the cycle before `done`, and low in the `done` cycle.
- `result` is registered; it changes only on the edge that enters DONE.

## Configuration
- Macro `DIV_EARLY_OUT_EN`.
  - Defined: in PREP, if |dividend| < |divisor| (non-zero divisor), skip ITER. Quotient = 0 and remainder = |dividend|, passed through FIX with normal sign correction. `done` is high in cycle 3.
  - Undefined: these operands take the full 35 cycles. Results are identical either way; only latency differs.

## Test plan
- DIVU 100/7, then REMU 100/7: result 14, done in cycle 35; then result 2, done in cycle 35.
- DIV −7/2 and REM −7/2: result 0xFFFFFFFD (−3) and 0xFFFFFFFF (−1). DIV 7/−2 gives 0xFFFFFFFD.
- Corner cases:
  - DIV 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5; DIV 0x80000000/−1 gives 0x80000000; REM with the same operands gives 0. Each has done in cycle 2.
  - DIVU 3/10: with `DIV_EARLY_OUT_EN` defined, result 0 with done in cycle 3. With the macro undefined, result 0 with done in cycle 35.
- Handshake:
  - Pulse `start` during ITER: ignored, no second done.
  - Assert `kill` in cycle 10: IDLE next cycle, `busy` low, no done, `result` keeps its previous value.
  - Assert `start` in the DONE cycle: the new operation is accepted and its done arrives 35 cycles later.
- Assert `rst_n` low mid-ITER: `busy`, `done` and `result` go to 0 immediately. The next `start` after release completes normally.

Source files
------------

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer
// Brief    : Multi-cycle RISC-V M-extension divide/remainder unit. Resolves
//            zero-divisor and signed-overflow cases in one preparation cycle;
//            all other operands run a 32-step shift-subtract iteration.
//            Optional macro DIV_EARLY_OUT_EN skips the iteration when
//            |dividend| < |divisor|.
// Revision : 1.0 - initial release
// ============================================================================
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int                 c_cnt_w    = $clog2(XLEN);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(XLEN - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [XLEN-1:0]    c_min_int  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured operation and operands
  logic [1:0]         r_op;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  // Iteration datapath
  logic               r_neg_q;
  logic               r_neg_r;
  logic [XLEN:0]      r_rem;
  logic [XLEN-1:0]    r_quo;
  logic [XLEN-1:0]    r_dvs;
  logic [c_cnt_w-1:0] r_cnt;
  logic [XLEN-1:0]    r_result;

  logic               w_accept;
  logic               w_signed;
  logic               w_is_rem;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [XLEN-1:0]    w_abs_a;
  logic [XLEN-1:0]    w_abs_b;
  logic               w_div_zero;
  logic               w_ovf;
  logic               w_early;
  logic [2*XLEN:0]    w_shift;
  logic [XLEN:0]      w_rem_sh;
  logic [XLEN-1:0]    w_quo_sh;
  logic [XLEN:0]      w_trial;
  logic               w_trial_ok;
  logic [XLEN-1:0]    w_fix_val;
  logic               w_fix_neg;
  logic [XLEN-1:0]    w_fix_res;
  logic [XLEN-1:0]    w_special_res;

  // op[0] selects unsigned, op[1] selects remainder
  assign w_signed   = ~r_op[0];
  assign w_is_rem   = r_op[1];
  assign w_a_neg    = w_signed & r_a[XLEN-1];
  assign w_b_neg    = w_signed & r_b[XLEN-1];
  assign w_abs_a    = w_a_neg ? (-r_a) : r_a;
  assign w_abs_b    = w_b_neg ? (-r_b) : r_b;
  assign w_div_zero = (r_b == '0);
  assign w_ovf      = w_signed && (r_a == c_min_int) && (r_b == '1);

`ifdef DIV_EARLY_OUT_EN
  // Quotient is trivially zero when the magnitude of the dividend is smaller
  assign w_early    = !w_div_zero && (w_abs_a < w_abs_b);
`else
  assign w_early    = 1'b0;
`endif

  // One restoring-division step: shift {rem,quo} left, trial-subtract divisor.
  // The partial remainder is always below the divisor, so the 33-bit trial's
  // top bit is a reliable sign.
  assign w_shift    = {r_rem, r_quo} << 1;
  assign w_rem_sh   = w_shift[2*XLEN:XLEN];
  assign w_quo_sh   = w_shift[XLEN-1:0];
  assign w_trial    = w_rem_sh - {1'b0, r_dvs};
  assign w_trial_ok = ~w_trial[XLEN];

  // Sign correction: quotient follows sign XOR, remainder follows dividend
  assign w_fix_val  = w_is_rem ? r_rem[XLEN-1:0] : r_quo;
  assign w_fix_neg  = w_is_rem ? r_neg_r : r_neg_q;
  assign w_fix_res  = w_fix_neg ? (-w_fix_val) : w_fix_val;

  // Zero divisor beats overflow; the two cannot coincide anyway
  assign w_special_res = w_div_zero ? (w_is_rem ? r_a : '1)
                                    : (w_is_rem ? '0  : c_min_int);

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !kill;
  assign result   = r_result;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; kill overrides every transition
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done         = (r_state == S_DONE);
        w_state_next = (start && !kill) ? S_PREP : S_IDLE;
      end
      S_PREP: begin
        busy = 1'b1;
        if (w_div_zero || w_ovf) begin
          w_state_next = S_DONE;
        end else if (w_early) begin
          w_state_next = S_FIX;
        end else begin
          w_state_next = S_ITER;
        end
      end
      S_ITER: begin
        busy = 1'b1;
        if (r_cnt == c_cnt_last) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (kill) begin
      w_state_next = S_IDLE;
    end
  end

  // Operand capture, iteration datapath and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op <= op;
        r_a  <= SrcA;
        r_b  <= SrcB;
      end
      if (r_state == S_PREP) begin
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_dvs   <= w_abs_b;
        r_cnt   <= '0;
        if (w_early) begin
          r_quo <= '0;
          r_rem <= {1'b0, w_abs_a};
        end else begin
          r_quo <= w_abs_a;
          r_rem <= '0;
        end
      end
      if (r_state == S_ITER) begin
        r_rem <= w_trial_ok ? w_trial : w_rem_sh;
        r_quo <= w_quo_sh | XLEN'(w_trial_ok);
        r_cnt <= r_cnt + c_cnt_one;
      end
      // Result only moves on the edge entering DONE, so a kill leaves it intact
      if (w_state_next == S_DONE) begin
        r_result <= (r_state == S_PREP) ? w_special_res : w_fix_res;
      end
    end
  end

endmodule
`default_nettype wire
